// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FWFT FIFO write port; a burst is granted only if it fits.
// Optional watchdog abort of stalled bursts when FIFO_ARB_TIMEOUT_EN is defined.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned LEN_WIDTH  = $clog2(MAX_BURST) + 1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_i,
  input  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]   len_i,
  input  logic [NUM_REQ-1:0]                  valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  data_i,
  output logic [NUM_REQ-1:0]                  ready_o,
  output logic [NUM_REQ-1:0]                  grant_o,
  output logic                                fifo_wen_o,
  output logic [DATA_WIDTH-1:0]               fifo_wdata_o,
  input  logic                                fifo_full_i,
  input  logic [ADDR_WIDTH:0]                 fifo_count_i,
  output logic                                busy_o,
  output logic                                abort_o
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam int unsigned CmpW = (LEN_WIDTH > CntW) ? LEN_WIDTH : CntW;
  localparam logic [CmpW-1:0] MaxBurstC = CmpW'(MAX_BURST);
  localparam logic [CmpW-1:0] DepthC    = CmpW'(FIFO_DEPTH);

  if (TIMEOUT < 1 || MAX_BURST < 1) begin : g_bad_params
    $error("fifo_wr_arbiter: TIMEOUT and MAX_BURST must be at least 1");
  end

  typedef enum logic {StIdle, StBurst} state_e;

  state_e                  state_q;
  logic [NUM_REQ-1:0]      grant_q;
  logic [PtrW-1:0]         rr_ptr_q;
  logic [PtrW-1:0]         owner_q;
  logic [LEN_WIDTH-1:0]    beats_left_q;

  logic [CmpW-1:0]                  count_ext;
  logic [CmpW-1:0]                  free_space;
  logic [NUM_REQ-1:0][LEN_WIDTH-1:0] eff_len;
  logic [NUM_REQ-1:0]               eligible;
  logic                             found;
  logic [PtrW-1:0]                  win_idx;
  logic [PtrW-1:0]                  idx;
  logic [PtrW-1:0]                  next_rr;
  logic                             beat;

  // Free space saturates at zero so a bogus count above depth blocks every grant.
  always_comb begin
    count_ext  = CmpW'(fifo_count_i);
    free_space = (count_ext >= DepthC) ? '0 : DepthC - count_ext;
    eff_len    = '0;
    eligible   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      eff_len[k]  = (CmpW'(len_i[k]) > MaxBurstC) ? LEN_WIDTH'(MAX_BURST) : len_i[k];
      eligible[k] = req_i[k] && (len_i[k] != '0) && (CmpW'(eff_len[k]) <= free_space);
    end
  end

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PtrW'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && eligible[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  assign next_rr = (owner_q == PtrW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign beat    = (state_q == StBurst) && !rst && valid_i[owner_q] && !fifo_full_i;

  // Handshake is combinational so a beat lands the same cycle valid is presented.
  always_comb begin
    ready_o      = '0;
    fifo_wen_o   = 1'b0;
    fifo_wdata_o = '0;
    if (state_q == StBurst && !rst) begin
      ready_o[owner_q] = !fifo_full_i;
      fifo_wen_o       = beat;
      fifo_wdata_o     = data_i[owner_q];
    end
  end

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  logic [WdogW-1:0] wdog_q;
  logic             abort_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      beats_left_q <= '0;
      wdog_q       <= '0;
      abort_q      <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          wdog_q <= '0;
          if (found) begin
            state_q      <= StBurst;
            grant_q      <= NUM_REQ'(1) << win_idx;
            owner_q      <= win_idx;
            beats_left_q <= eff_len[win_idx];
          end
        end
        StBurst: begin
          if (beat) begin
            wdog_q       <= '0;
            beats_left_q <= beats_left_q - 1'b1;
            if (beats_left_q == LEN_WIDTH'(1)) begin
              state_q  <= StIdle;
              grant_q  <= '0;
              rr_ptr_q <= next_rr;
            end
          end else if (wdog_q == WdogW'(TIMEOUT - 1)) begin
            // Beats already written stay in the FIFO; only the remainder is dropped.
            state_q      <= StIdle;
            grant_q      <= '0;
            rr_ptr_q     <= next_rr;
            beats_left_q <= '0;
            wdog_q       <= '0;
            abort_q      <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign abort_o = abort_q;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      beats_left_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            state_q      <= StBurst;
            grant_q      <= NUM_REQ'(1) << win_idx;
            owner_q      <= win_idx;
            beats_left_q <= eff_len[win_idx];
          end
        end
        StBurst: begin
          if (beat) begin
            beats_left_q <= beats_left_q - 1'b1;
            if (beats_left_q == LEN_WIDTH'(1)) begin
              state_q  <= StIdle;
              grant_q  <= '0;
              rr_ptr_q <= next_rr;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign abort_o = 1'b0;
`endif

  assign grant_o = grant_q;
  assign busy_o  = (state_q == StBurst);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected FIFO writes queued at stimulus, checked on wen.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int MAX_BURST  = 4;
  localparam int LEN_WIDTH  = 3;
  localparam int TIMEOUT    = 16;

  logic                               clk = 1'b0;
  logic                               rst;
  logic [NUM_REQ-1:0]                 req;
  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]  len;
  logic [NUM_REQ-1:0]                 valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data;
  logic [NUM_REQ-1:0]                 ready;
  logic [NUM_REQ-1:0]                 grant;
  logic                               wen;
  logic [DATA_WIDTH-1:0]              wdata;
  logic                               full;
  logic [ADDR_WIDTH:0]                count;
  logic                               busy;
  logic                               abort;

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MAX_BURST (MAX_BURST),
    .LEN_WIDTH (LEN_WIDTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .len_i       (len),
    .valid_i     (valid),
    .data_i      (data),
    .ready_o     (ready),
    .grant_o     (grant),
    .fifo_wen_o  (wen),
    .fifo_wdata_o(wdata),
    .fifo_full_i (full),
    .fifo_count_i(count),
    .busy_o      (busy),
    .abort_o     (abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_REQ-1:0]    grant;
    logic [DATA_WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors  = 0;
  int   checks  = 0;
  int   wen_cnt = 0;
  int   seq     [NUM_REQ];
  int   exp_seq [NUM_REQ];

  initial for (int k = 0; k < NUM_REQ; k++) begin
    seq[k]     = 0;
    exp_seq[k] = 0;
  end

  // Each producer emits a running sequence tagged with its index; advances on accepted beats.
  always @(posedge clk) begin
    for (int k = 0; k < NUM_REQ; k++) if (valid[k] && ready[k]) seq[k] <= seq[k] + 1;
  end

  always_comb begin
    data = '0;
    for (int k = 0; k < NUM_REQ; k++) data[k] = DATA_WIDTH'((k << 5) | (seq[k] & 31));
  end

  always @(negedge clk) begin
    if (!rst && wen) begin
      wen_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: wen with data=%h grant=%b, required no write", wdata, grant);
      end else begin
        mon_e = exp_q.pop_front();
        if (wdata !== mon_e.data || grant !== mon_e.grant) begin
          errors++;
          $display("FAIL sb_beat: data=%h grant=%b, required data=%h grant=%b",
                   wdata, grant, mon_e.data, mon_e.grant);
        end
      end
    end
  end

  task automatic push_exp(input int k, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.grant = NUM_REQ'(1) << k;
      e.data  = DATA_WIDTH'((k << 5) | (exp_seq[k] & 31));
      exp_q.push_back(e);
      exp_seq[k]++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      next_cycle();
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    valid = '0;
    len   = '0;
    full  = 1'b0;
    count = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req   = '1;
    len   = '1;
    valid = '1;
    full  = 1'b0;
    count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant !== '0 || busy !== 1'b0 || abort !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: grant=%b busy=%b abort=%b, required 0", grant, busy, abort);
    end
    checks++;
    if (ready !== '0 || wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: ready=%b wen=%b, required 0", ready, wen);
    end
    do_reset();
  endtask

  task automatic test_single_burst();
    int w0;
    bit ok;
    do_reset();
    w0     = wen_cnt;
    len[0] = 3'd3;
    req    = 4'b0001;
    valid  = 4'b0001;
    push_exp(0, 3);
    @(negedge clk);
    checks++;
    if (grant !== '0 || wen !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: grant=%b wen=%b, required 0000/0", grant, wen);
    end
    next_cycle();
    req = '0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: grant=%b busy=%b, required 0001/1", grant, busy);
    end
    wait_idle(10, ok);
    checks++;
    if (!ok || grant !== '0) begin
      errors++;
      $display("FAIL single_end: idle=%0d grant=%b, required 1/0000", ok, grant);
    end
    checks++;
    if (wen_cnt - w0 !== 3) begin
      errors++;
      $display("FAIL single_beats: %0d writes, required 3", wen_cnt - w0);
    end
    valid = '0;
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] pat [9];
    bit ok;
    do_reset();
    pat   = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    len   = {3'd1, 3'd1, 3'd1, 3'd1};
    req   = 4'b1111;
    valid = 4'b1111;
    push_exp(0, 1);
    push_exp(1, 1);
    push_exp(2, 1);
    push_exp(3, 1);
    push_exp(0, 1);
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      if (i == 8) req = '0;
      @(negedge clk);
      checks++;
      if (grant !== pat[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: grant=%b, required %b", i, grant, pat[i]);
      end
    end
    wait_idle(5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_end: busy=%b, required 0", busy);
    end
    valid = '0;
  endtask

  task automatic test_space_check();
    bit ok;
    do_reset();
    count  = 4'd6;
    len[0] = 3'd3;
    len[1] = 3'd2;
    req    = 4'b0011;
    valid  = 4'b0011;
    push_exp(1, 2);
    next_cycle();
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL space_skip: grant=%b, required 0010", grant);
    end
    wait_idle(10, ok);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (grant !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL space_hold[%0d]: grant=%b busy=%b, required 0000/0", i, grant, busy);
      end
    end
    next_cycle();
    count = 4'd5;
    push_exp(0, 3);
    next_cycle();
    req = '0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL space_fit: grant=%b, required 0001", grant);
    end
    wait_idle(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL space_end: busy=%b, required 0", busy);
    end
    valid = '0;
    count = '0;
  endtask

  task automatic test_max_burst();
    int w0;
    bit ok;
    do_reset();
    w0     = wen_cnt;
    len[0] = 3'd7;
    req    = 4'b0001;
    valid  = 4'b0001;
    push_exp(0, 4);
    next_cycle();
    req = '0;
    wait_idle(10, ok);
    checks++;
    if (!ok || wen_cnt - w0 !== 4) begin
      errors++;
      $display("FAIL max_burst: idle=%0d writes=%0d, required 1/4", ok, wen_cnt - w0);
    end
    len[0] = 3'd0;
    req    = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (grant !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_len[%0d]: grant=%b busy=%b, required 0000/0", i, grant, busy);
      end
    end
    req   = '0;
    valid = '0;
  endtask

  task automatic test_full_stall();
    int w0;
    bit ok;
    do_reset();
    w0     = wen_cnt;
    full   = 1'b1;
    len[0] = 3'd2;
    req    = 4'b0001;
    valid  = 4'b0001;
    push_exp(0, 2);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      req = '0;
      @(negedge clk);
      checks++;
      if (ready !== '0 || wen !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL full_stall[%0d]: ready=%b wen=%b busy=%b, required 0000/0/1",
                 i, ready, wen, busy);
      end
    end
    next_cycle();
    full = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 4'b0001 || wen !== 1'b1) begin
      errors++;
      $display("FAIL full_resume: ready=%b wen=%b, required 0001/1", ready, wen);
    end
    wait_idle(10, ok);
    checks++;
    if (!ok || wen_cnt - w0 !== 2) begin
      errors++;
      $display("FAIL full_beats: idle=%0d writes=%0d, required 1/2", ok, wen_cnt - w0);
    end
    valid = '0;
  endtask

  task automatic test_mid_reset();
    bit ok;
    do_reset();
    len[0] = 3'd1;
    req    = 4'b0001;
    valid  = 4'b0001;
    push_exp(0, 1);
    next_cycle();
    req = '0;
    wait_idle(5, ok);
    valid  = 4'b0100;
    len[2] = 3'd4;
    req    = 4'b0100;
    push_exp(2, 2);
    next_cycle();
    req = '0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_grant: grant=%b, required 0100", grant);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (wen !== 1'b1) begin
      errors++;
      $display("FAIL midrst_beat2: wen=%b, required 1", wen);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wen !== 1'b0 || ready !== '0) begin
      errors++;
      $display("FAIL midrst_force: wen=%b ready=%b, required 0/0000", wen, ready);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== '0 || busy !== 1'b0 || wen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: grant=%b busy=%b wen=%b, required 0000/0/0", grant, busy, wen);
    end
    next_cycle();
    valid  = 4'b0011;
    len[0] = 3'd1;
    len[1] = 3'd1;
    req    = 4'b0011;
    push_exp(0, 1);
    push_exp(1, 1);
    next_cycle();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_rr: grant=%b, required 0001", grant);
    end
    next_cycle();
    next_cycle();
    req = '0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_next: grant=%b, required 0010", grant);
    end
    wait_idle(5, ok);
    valid = '0;
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    bit seen;
    do_reset();
    len[0] = 3'd3;
    req    = 4'b0001;
    valid  = 4'b0001;
    push_exp(0, 1);
    next_cycle();
    req = '0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL tmo_grant: grant=%b, required 0001", grant);
    end
    next_cycle();
    valid = '0;
`ifdef FIFO_ARB_TIMEOUT_EN
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (abort) begin
        n = i;
        break;
      end
      next_cycle();
    end
    checks++;
    if (n !== TIMEOUT + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_abort: abort at cycle %0d busy=%b, required %0d/0", n, busy, TIMEOUT + 1);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (abort !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse: abort=%b, required 0", abort);
    end
`else
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      @(negedge clk);
      if (abort) seen = 1'b1;
    end
    checks++;
    if (seen || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_none: abort_seen=%0d busy=%b, required 0/1", seen, busy);
    end
    valid = 4'b0001;
    push_exp(0, 2);
    wait_idle(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tmo_finish: busy=%b, required 0", busy);
    end
    valid = '0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running, required completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_space_check();
    test_max_burst();
    test_full_stall();
    test_mid_reset();
    test_timeout();
    repeat (3) next_cycle();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d writes outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
